// File: rtl/alarm_pkg.sv
// Shared state encoding and default chime timing for the alarm path.
// The tester uses the same defaults so its expected beep patterns line up.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        MUTED    = 3'd4,
        DONE     = 3'd5
    } alarmState_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_BEEP_ON_CYCLES  = 8;
    localparam int unsigned DEF_BEEP_OFF_CYCLES = 8;
    localparam int unsigned DEF_MAX_BEEPS       = 6;
    localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/alarm_cycle_timer.sv
// Shared cycle counter: sync clear has priority over enable; atTerminal compares count to terminal.
// Output valid the cycle after the count update; no backpressure.
module alarm_cycle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             atTerminal
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    assign atTerminal = (count == terminal);

endmodule

// File: rtl/alarm_chime_driver.sv
// Debounced alarm-to-buzzer driver with pulsed beeps, driver mute and auto-silence after MAX_BEEPS.
// First BuzzerOut high after DEBOUNCE_CYCLES high samples; all outputs registered; no backpressure.
module alarm_chime_driver
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned BEEP_ON_CYCLES  = DEF_BEEP_ON_CYCLES,
    parameter int unsigned BEEP_OFF_CYCLES = DEF_BEEP_OFF_CYCLES,
    parameter int unsigned MAX_BEEPS       = DEF_MAX_BEEPS,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             CarAlarmSignal,
    input  logic             DriverAck,
    output logic             BuzzerOut,
    output logic             AlarmActive,
    output logic             Muted,
    output logic [CNT_W-1:0] BeepCount
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEEPS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    alarmState_t      state, nextState;
    logic             timerClear, timerEnable, timerDone;
    logic [CNT_W-1:0] timerTerm;

    alarm_cycle_timer #(.CNT_W(CNT_W)) uTimer (
        .clk        (clk),
        .reset_L    (reset_L),
        .clear      (timerClear),
        .enable     (timerEnable),
        .terminal   (timerTerm),
        .atTerminal (timerDone)
    );

    always_comb begin
        nextState   = state;
        timerTerm   = '0;
        timerEnable = 1'b0;
        case (state)
            IDLE: begin
                // Entering ARM counts the first high sample, so the timer steps to 1
                if (CarAlarmSignal) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        nextState = BEEP_ON;
                    end else begin
                        nextState   = ARM;
                        timerEnable = 1'b1;
                    end
                end
            end
            ARM: begin
                timerTerm = DEB_LAST;
                if (!CarAlarmSignal)  nextState = IDLE;
                else if (timerDone)   nextState = BEEP_ON;
                else                  timerEnable = 1'b1;
            end
            BEEP_ON: begin
                timerTerm = ON_LAST;
                if (!CarAlarmSignal)  nextState = IDLE;
                else if (DriverAck)   nextState = MUTED;
                else if (timerDone)   nextState = (BeepCount == MAX_CNT) ? DONE : BEEP_OFF;
                else                  timerEnable = 1'b1;
            end
            BEEP_OFF: begin
                timerTerm = OFF_LAST;
                if (!CarAlarmSignal)  nextState = IDLE;
                else if (DriverAck)   nextState = MUTED;
                else if (timerDone)   nextState = BEEP_ON;
                else                  timerEnable = 1'b1;
            end
            MUTED, DONE: begin
                if (!CarAlarmSignal)  nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        timerClear = (nextState != state) && (nextState != ARM);
    end

    // Outputs decode the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state       <= IDLE;
            BuzzerOut   <= 1'b0;
            AlarmActive <= 1'b0;
            Muted       <= 1'b0;
            BeepCount   <= '0;
        end else begin
            state       <= nextState;
            BuzzerOut   <= (nextState == BEEP_ON);
            AlarmActive <= (nextState != IDLE);
            Muted       <= (nextState == MUTED);
            if (nextState == IDLE) begin
                BeepCount <= '0;
            end else if (nextState == BEEP_ON && state != BEEP_ON && BeepCount != MAX_CNT) begin
                BeepCount <= BeepCount + ONE;
            end
        end
    end

endmodule

// File: tb/tb_alarm_chime_driver.sv
// Bench for alarm_chime_driver: directed scenarios plus random traffic against a
// timeline model that derives beep position from the length of the current alarm run.
module tb_alarm_chime_driver;
    import alarm_pkg::*;

    localparam int W    = DEF_CNT_W;
    localparam int D    = DEF_DEBOUNCE_CYCLES;
    localparam int ONC  = DEF_BEEP_ON_CYCLES;
    localparam int OFFC = DEF_BEEP_OFF_CYCLES;
    localparam int MAXB = DEF_MAX_BEEPS;
    localparam int P    = ONC + OFFC;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         CarAlarmSignal = 1'b0;
    logic         DriverAck = 1'b0;
    logic         BuzzerOut, AlarmActive, Muted;
    logic [W-1:0] BeepCount;

    int total = 0;
    int bad   = 0;

    // Model: length of the current uninterrupted alarm run, mute flag, frozen count
    int mRun    = 0;
    bit mMuted  = 1'b0;
    int mFrozen = 0;

    alarm_chime_driver dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .CarAlarmSignal (CarAlarmSignal),
        .DriverAck      (DriverAck),
        .BuzzerOut      (BuzzerOut),
        .AlarmActive    (AlarmActive),
        .Muted          (Muted),
        .BeepCount      (BeepCount)
    );

    always #5 clk = ~clk;

    function automatic bit modelBeeping();
        return (mRun >= D) && !mMuted && ((mRun - D) < (MAXB - 1) * P + ONC);
    endfunction

    // {BuzzerOut, AlarmActive, Muted, BeepCount}
    function automatic logic [W+2:0] modelOut();
        int k;
        if (mRun == 0) return '0;
        if (mMuted) return {3'b011, W'(mFrozen)};
        if (mRun < D) return {3'b010, {W{1'b0}}};
        k = mRun - D;
        if (k >= (MAXB - 1) * P + ONC) return {3'b010, W'(MAXB)};
        return {((k % P) < ONC), 2'b10, W'(k / P + 1)};
    endfunction

    task automatic tick(input logic a, input logic k, input logic r);
        @(negedge clk);
        CarAlarmSignal = a;
        DriverAck      = k;
        reset_L        = r;
        @(posedge clk);
        if (!r || !a) begin
            mRun   = 0;
            mMuted = 1'b0;
        end else begin
            if (k && modelBeeping()) begin
                mMuted  = 1'b1;
                mFrozen = (mRun - D) / P + 1;
            end
            mRun = mRun + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [W+2:0] got;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL reset_hold cycle=%0d got=%h exp=0", i, got);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            total++;
            if (BuzzerOut !== (i == 4)) begin
                bad++;
                $display("FAIL first_beep_latency edge=%0d got=%b exp=%b", i, BuzzerOut, (i == 4));
            end
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== modelOut()) begin
                bad++;
                $display("FAIL reset_release edge=%0d got=%h exp=%h", i, got, modelOut());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_glitch();
        logic [7:0]   pat;
        logic [W+2:0] got;
        pat = 8'b1111_0111;  // applied LSB first: 3 high, 1 low, 4 high
        for (int i = 0; i < 8; i++) begin
            tick(pat[i], 1'b0, 1'b1);
            total++;
            if (BuzzerOut !== (i == 7)) begin
                bad++;
                $display("FAIL glitch_buzzer step=%0d got=%b exp=%b", i, BuzzerOut, (i == 7));
            end
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== modelOut()) begin
                bad++;
                $display("FAIL glitch_model step=%0d got=%h exp=%h", i, got, modelOut());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_cycle();
        logic [W+2:0] got;
        int   rises = 0;
        int   highs = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < D + MAXB * P + 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (BuzzerOut === 1'b1 && prev === 1'b0) rises++;
            if (BuzzerOut === 1'b1) highs++;
            prev = BuzzerOut;
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== modelOut()) begin
                bad++;
                $display("FAIL full_cycle_model step=%0d got=%h exp=%h", i, got, modelOut());
            end
        end
        total++;
        if (rises != 6 || highs != 48) begin
            bad++;
            $display("FAIL full_cycle_pulses got=%0d/%0d exp=6/48", rises, highs);
        end
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== {3'b010, W'(6)}) begin
            bad++;
            $display("FAIL done_state got=%h exp=%h", got, {3'b010, W'(6)});
        end
        tick(1'b0, 1'b0, 1'b1);
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL done_to_idle got=%h exp=0", got);
        end
    endtask

    task automatic test_mute();
        logic [W+2:0] got;
        for (int i = 0; i < D + P + 3; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== {3'b011, W'(2)}) begin
            bad++;
            $display("FAIL mute_enter got=%h exp=%h", got, {3'b011, W'(2)});
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== modelOut()) begin
                bad++;
                $display("FAIL mute_hold step=%0d got=%h exp=%h", i, got, modelOut());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL mute_release got=%h exp=0", got);
        end
    endtask

    task automatic test_ack_and_drop();
        logic [W+2:0] got;
        for (int i = 0; i < D + 2; i++) tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL ack_and_drop step=%0d got=%h exp=0", i, got);
            end
        end
    endtask

    task automatic test_reset_midbeep();
        logic [W+2:0] got;
        for (int i = 0; i < D + 2 * P + ONC + 2; i++) tick(1'b1, 1'b0, 1'b1);
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== {3'b010, W'(3)}) begin
            bad++;
            $display("FAIL beep3_off got=%h exp=%h", got, {3'b010, W'(3)});
        end
        tick(1'b1, 1'b0, 1'b0);
        got = {BuzzerOut, AlarmActive, Muted, BeepCount};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL midbeep_reset got=%h exp=0", got);
        end
        for (int i = 1; i <= D; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            total++;
            if (BeepCount !== W'(i == D)) begin
                bad++;
                $display("FAIL redebounce edge=%0d got=%0d exp=%0d", i, BeepCount, (i == D));
            end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [W+2:0] got;
        logic a, k, r;
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 149) != 0);
            k = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 499) != 0);
            tick(a, k, r);
            got = {BuzzerOut, AlarmActive, Muted, BeepCount};
            total++;
            if (got !== modelOut()) begin
                bad++;
                $display("FAIL random step=%0d a=%b k=%b r=%b got=%h exp=%h", i, a, k, r, got, modelOut());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_full_cycle();
        test_mute();
        test_ack_and_drop();
        test_reset_midbeep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
